// File: rtl/l2_pmem_burst_responder_pkg.sv
// Shared constants and types for the L2 physical-memory burst responder.
package l2_mem_pkg;

   localparam int LINE_W      = 256;
   localparam int BEAT_W      = 64;
   localparam int BEATS       = LINE_W / BEAT_W;
   localparam int OFFSET_BITS = 5;

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_BURST,
      DONE
   } burst_state_t;

   // Align an address to the start of its cache line.
   function automatic logic [31:0] line_base(input logic [31:0] addr);
      return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/l2_pmem_burst_responder_if.sv
// L2-side line interface plus memory-side burst interface, bundled.
// slave: the responder. master: whoever plays L2 and the burst memory.
interface l2_pmem_burst_responder_if #(
   parameter int LINE_W = l2_mem_pkg::LINE_W,
   parameter int BEAT_W = l2_mem_pkg::BEAT_W
);

   // L2 cache side
   logic [31:0]       pmem_address;
   logic              pmem_read;
   logic              pmem_write;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   // burst memory side
   logic [31:0]       bmem_address;
   logic              bmem_read;
   logic              bmem_write;
   logic [BEAT_W-1:0] bmem_wdata;
   logic [BEAT_W-1:0] bmem_rdata;
   logic              bmem_resp;

   modport slave (
      input  pmem_address, pmem_read, pmem_write, pmem_wdata,
      input  bmem_rdata, bmem_resp,
      output pmem_rdata, pmem_resp,
      output bmem_address, bmem_read, bmem_write, bmem_wdata
   );

   modport master (
      output pmem_address, pmem_read, pmem_write, pmem_wdata,
      output bmem_rdata, bmem_resp,
      input  pmem_rdata, pmem_resp,
      input  bmem_address, bmem_read, bmem_write, bmem_wdata
   );

endinterface

// File: rtl/l2_pmem_burst_responder_line_shift_buffer.sv
// One cache line held as BEATS beats. A whole line can be loaded at once,
// or a single beat written by index; a single beat can be read by index.
module line_shift_buffer #(
   parameter int LINE_W = l2_mem_pkg::LINE_W,
   parameter int BEAT_W = l2_mem_pkg::BEAT_W,
   parameter int IDX_W  = $clog2(LINE_W / BEAT_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_en,
   input  logic [LINE_W-1:0] ld_line,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [BEAT_W-1:0] wr_beat,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [BEAT_W-1:0] rd_beat,
   output logic [LINE_W-1:0] line
);

   localparam int BEATS = LINE_W / BEAT_W;

   // beat 0 sits in the low bits, so the packed view equals the line
   logic [BEATS-1:0][BEAT_W-1:0] beats_q;

   // whole-line load wins over a single-beat write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         beats_q <= '0;
      else if (ld_en)
         beats_q <= ld_line;
      else if (wr_en)
         beats_q[wr_idx] <= wr_beat;
   end

   assign line    = beats_q;
   assign rd_beat = beats_q[rd_idx];

endmodule

// File: rtl/l2_pmem_burst_responder.sv
// Turns single-line L2 read/write-back requests into fixed 4-beat bursts
// toward main memory and answers L2 with a one-cycle pmem_resp.
module l2_pmem_burst_responder
   import l2_mem_pkg::*;
#(
   parameter int LINE_W = l2_mem_pkg::LINE_W,
   parameter int BEAT_W = l2_mem_pkg::BEAT_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   l2_pmem_burst_responder_if.slave  bus
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   burst_state_t      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       addr_q;
   logic              ld_addr;
   logic              ld_wline;
   logic              rd_we;
   logic [BEAT_W-1:0] wr_beat;
   logic [BEAT_W-1:0] rd_beat_unused;
   logic [LINE_W-1:0] wr_line_unused;

   // state register and beat counter; reset abandons any burst in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state, counter and capture strobes; write beats read on a tie
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ld_addr  = 1'b0;
      ld_wline = 1'b0;
      rd_we    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.pmem_write) begin
               ld_addr  = 1'b1;
               ld_wline = 1'b1;
               state_d  = WR_BURST;
            end else if (bus.pmem_read) begin
               ld_addr = 1'b1;
               state_d = RD_BURST;
            end
         end
         RD_BURST, WR_BURST: begin
            if (bus.bmem_resp) begin
               rd_we = (state_q == RD_BURST);
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // burst base address, frozen for the whole burst
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         addr_q <= '0;
      else if (ld_addr)
         addr_q <= line_base(bus.pmem_address);
   end

   // read assembly: memory beats land at the counter position
   line_shift_buffer #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) u_rd_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_en   (1'b0),
      .ld_line ('0),
      .wr_en   (rd_we),
      .wr_idx  (cnt_q),
      .wr_beat (bus.bmem_rdata),
      .rd_idx  (cnt_q),
      .rd_beat (rd_beat_unused),
      .line    (bus.pmem_rdata)
   );

   // write disassembly: line captured at accept, beats picked by counter
   line_shift_buffer #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) u_wr_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_en   (ld_wline),
      .ld_line (bus.pmem_wdata),
      .wr_en   (1'b0),
      .wr_idx  ('0),
      .wr_beat ('0),
      .rd_idx  (cnt_q),
      .rd_beat (wr_beat),
      .line    (wr_line_unused)
   );

   assign bus.bmem_address = addr_q;
   assign bus.bmem_read    = (state_q == RD_BURST);
   assign bus.bmem_write   = (state_q == WR_BURST);
   assign bus.bmem_wdata   = (state_q == WR_BURST) ? wr_beat : '0;
   assign bus.pmem_resp    = (state_q == DONE);

endmodule
